burst_write_issuer: RTL and testbench
=====================================

Name: burst_write_issuer

Overview:
- Downstream consumer of the burst detector.
- Takes merged `{burst_len, base_addr}` requests and a per-burst length stream, plus a beat-ordered write-data FIFO, and drives an AXI4 write master: AW, W with correct WLAST, and B.
- Reports each completed burst to a response FIFO, so the memory-port wrapper can count retired writes.
- Burst length encoding throughout: `len` = beats − 1, identical to AXI AWLEN.

Parameters:
- `AddrWidth`, 64, byte address width.
- `DataWidth`, 512, AXI data width in bits; `DataWidthBytesLog` = log2(`DataWidth`/8) is a localparam.
- `BurstLenWidth`, 8, width of the length field (AWLEN).
- `MaxOutstanding`, 16, maximum AW issued without a B response; must be a power of 2 and ≥2.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `addr_dout`  in  `BurstLenWidth`+`AddrWidth`  `{len, addr}` request, FWFT
- `addr_empty_n`  in  1  request valid
- `addr_read`  out  1  pop request
- `burst_len_dout`  in  `BurstLenWidth`  per-burst len for the W path, FWFT
- `burst_len_empty_n`  in  1  len valid
- `burst_len_read`  out  1  pop len
- `data_dout`  in  `DataWidth`  write beat, FWFT
- `data_empty_n`  in  1  beat valid
- `data_read`  out  1  pop beat
- `m_axi_awaddr`  out  `AddrWidth`  AW address
- `m_axi_awlen`  out  `BurstLenWidth`  AW length
- `m_axi_awsize`  out  3  constant `DataWidthBytesLog`
- `m_axi_awburst`  out  2  constant 2'b01 (INCR)
- `m_axi_awvalid`  out  1
- `m_axi_awready`  in  1
- `m_axi_wdata`  out  `DataWidth`
- `m_axi_wstrb`  out  `DataWidth`/8  all ones
- `m_axi_wlast`  out  1
- `m_axi_wvalid`  out  1
- `m_axi_wready`  in  1
- `m_axi_bresp`  in  2
- `m_axi_bvalid`  in  1
- `m_axi_bready`  out  1
- `resp_din`  out  `BurstLenWidth`+2  `{err, beats}`; `beats` = len+1
- `resp_full_n`  in  1
- `resp_write`  out  1

Behaviour:
- All outputs are driven from registers or from FWFT inputs gated by state. While `rst_n`=0, every read/write/valid/ready output is 0, combinationally forced.
- Reset state: `awvalid`=0, W FSM=IDLE, `beats_left`=0, `outstanding`=0, length-tracking FIFO empty.

AW path (registered output stage):
- `can_load` = (!`awvalid` || `awready`) && `addr_empty_n` && `outstanding` < `MaxOutstanding` && `len_fifo` not full.
- `addr_read` = `can_load`. On `can_load`, next cycle: `awaddr` = `addr_dout[AddrWidth-1:0]`, `awlen` = `addr_dout[top]`, `awvalid` = 1.
- Latency: one cycle from pop to `awvalid`.
- When `awvalid && awready && !can_load`, `awvalid` drops to 0.
- AW fields are held stable while `awvalid && !awready`.
- On `addr_read`, push `awlen` into `len_fifo`.

W path, FSM with states IDLE and BURST:
- IDLE: if `burst_len_empty_n`, then `burst_len_read`=1, `beats_left` ← `burst_len_dout`, go to BURST. `wvalid`=0 in IDLE.
- BURST: `wvalid` = `data_empty_n`; `wdata` = `data_dout`; `wlast` = (`beats_left` == 0); `data_read` = `wvalid` && `wready`.
  - On a handshake with `wlast`: go to IDLE.
  - On a handshake without `wlast`: `beats_left` −1.
- `len` = 0 gives a single-beat burst with `wlast` on the first beat.
- W may lead AW; this is AXI-legal and no ordering between the paths is enforced.
- There is one idle cycle between bursts. This is accepted; throughput is at most len+1 beats per len+2 cycles.

B path:
- `bready` = `resp_full_n` && `len_fifo` non-empty.
- On `bvalid && bready`:
  - pop `len_fifo`;
  - `resp_din` = {`bresp` != 2'b00, `len` + 1}, where `len`+1 is computed in `BurstLenWidth`+1 bits so that 255 gives 256;
  - `resp_write` = 1 in the same cycle.
- A B arriving with `len_fifo` empty is a protocol violation. It is not accepted, because `bready` is 0.

Outstanding counter:
- Width is $clog2(`MaxOutstanding`)+1.
- +1 on `addr_read`, −1 on B handshake. Both in the same cycle leaves it unchanged.
- When it equals `MaxOutstanding`, `addr_read` is blocked; there is no wrap.

Other:
- Reset mid-burst: all state is cleared, in-flight AXI transactions are abandoned, and upstream FIFOs are not drained.

Decomposition:
- Shared package: `AXI_BURST_INCR`=2'b01, `AXI_RESP_OKAY`=2'b00, and the `{err, beats}` resp layout widths.
- One sub-module: `fifo_srl`, a shift-register FWFT FIFO, depth `MaxOutstanding`, width `BurstLenWidth`, used as `len_fifo`.

Test Plan:
- Single request {len=3, addr=0x1000}, burst_len=3, 4 data beats, all ready=1:
  - AW 0x1000/3 one cycle after `addr_read`;
  - W beats 0..3 with `wlast` only on beat 3;
  - B OKAY, then `resp_din`={0, 4}.
- len=0 request → exactly one W beat with `wlast`=1; `resp_din` beats=1.
- len=255 → 256 W beats; `resp_din` beats=256 with no truncation.
- Issue 20 requests with `bvalid` held 0 → exactly 16 AW handshakes and `addr_read` stalls. Release one B → the 17th AW issues on the following cycle.
- `awready`=0 for 5 cycles → `awaddr`/`awlen` stable and `awvalid` held; `data_empty_n` toggling mid-burst → `wvalid` follows it, `wlast` position unchanged.
- `bresp`=2'b10 → `resp_din` err=1. `resp_full_n`=0 → `bready`=0, and B stays pending until released.
- Assert `rst_n`=0 mid-burst → next cycle `awvalid`/`wvalid`/`bready`=0 and outstanding=0. A new request after reset completes normally.

Source files
------------

// File: rtl/burst_write_issuer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_write_issuer_pkg                                               |
// | AXI constants, response-word layout and W-path state encoding.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package burst_write_issuer_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // resp word is {err, beats}; beats carries one extra bit so len=max+1 fits
  localparam int RESP_ERR_W         = 1;
  localparam int RESP_BEATS_EXTRA_W = 1;

  typedef enum logic [0:0] {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } w_state_e;

endpackage
`default_nettype wire

// File: rtl/burst_write_issuer_fifo_srl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_srl                                                             |
// | Shift-register first-word-fall-through FIFO.                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_srl #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int                 c_IDX_W = $clog2(DEPTH);
  localparam logic [c_IDX_W:0]   c_FULL  = (c_IDX_W + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_IDX_W:0]   r_count;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic               w_push;
  logic               w_pop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == c_FULL);
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;
  // newest entry sits at index 0, so the oldest is at count-1
  assign w_rd_idx = r_count[c_IDX_W-1:0] - c_IDX_W'(1);
  assign o_dout   = r_mem[w_rd_idx];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_IDX_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_IDX_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/burst_write_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | burst_write_issuer                                                   |
// | Turns {len, addr} requests plus a beat stream into AXI4 write bursts.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module burst_write_issuer
  import burst_write_issuer_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [BURST_LEN_WIDTH+ADDR_WIDTH-1:0] addr_dout,
  input  logic                                  addr_empty_n,
  output logic                                  addr_read,
  input  logic [BURST_LEN_WIDTH-1:0]            burst_len_dout,
  input  logic                                  burst_len_empty_n,
  output logic                                  burst_len_read,
  input  logic [DATA_WIDTH-1:0]                 data_dout,
  input  logic                                  data_empty_n,
  output logic                                  data_read,
  output logic [ADDR_WIDTH-1:0]                 m_axi_awaddr,
  output logic [BURST_LEN_WIDTH-1:0]            m_axi_awlen,
  output logic [2:0]                            m_axi_awsize,
  output logic [1:0]                            m_axi_awburst,
  output logic                                  m_axi_awvalid,
  input  logic                                  m_axi_awready,
  output logic [DATA_WIDTH-1:0]                 m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]               m_axi_wstrb,
  output logic                                  m_axi_wlast,
  output logic                                  m_axi_wvalid,
  input  logic                                  m_axi_wready,
  input  logic [1:0]                            m_axi_bresp,
  input  logic                                  m_axi_bvalid,
  output logic                                  m_axi_bready,
  output logic [BURST_LEN_WIDTH+RESP_ERR_W+RESP_BEATS_EXTRA_W-1:0] resp_din,
  input  logic                                  resp_full_n,
  output logic                                  resp_write
);

  localparam int               c_OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_OUTSTANDING);
  localparam logic [2:0]       c_AWSIZE  = 3'($clog2(DATA_WIDTH / 8));

  logic                       r_awvalid;
  logic [ADDR_WIDTH-1:0]      r_awaddr;
  logic [BURST_LEN_WIDTH-1:0] r_awlen;
  logic [c_OUT_W-1:0]         r_outstanding;
  w_state_e                   r_wstate;
  logic [BURST_LEN_WIDTH-1:0] r_beats_left;

  logic                       w_can_load;
  logic [BURST_LEN_WIDTH-1:0] w_req_len;
  logic [BURST_LEN_WIDTH-1:0] w_len_dout;
  logic                       w_len_empty;
  logic                       w_len_full;
  logic                       w_in_burst;
  logic                       w_w_hs;
  logic                       w_b_hs;
  logic [BURST_LEN_WIDTH:0]   w_beats;

  // ---------------- AW path ----------------
  assign w_req_len  = addr_dout[ADDR_WIDTH +: BURST_LEN_WIDTH];
  assign w_can_load = (!r_awvalid || m_axi_awready) && addr_empty_n &&
                      (r_outstanding < c_MAX_OUT) && !w_len_full;
  assign addr_read  = rst_n && w_can_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
    end else if (w_can_load) begin
      r_awvalid <= 1'b1;
      r_awaddr  <= addr_dout[ADDR_WIDTH-1:0];
      r_awlen   <= w_req_len;
    end else if (m_axi_awready) begin
      r_awvalid <= 1'b0;
    end
  end

  assign m_axi_awvalid = rst_n && r_awvalid;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = c_AWSIZE;
  assign m_axi_awburst = AXI_BURST_INCR;

  // ---------------- W path ----------------
  assign burst_len_read = rst_n && (r_wstate == W_IDLE) && burst_len_empty_n;
  assign w_in_burst     = rst_n && (r_wstate == W_BURST);
  assign m_axi_wvalid   = w_in_burst && data_empty_n;
  assign m_axi_wdata    = data_dout;
  assign m_axi_wstrb    = '1;
  assign m_axi_wlast    = w_in_burst && (r_beats_left == '0);
  assign w_w_hs         = m_axi_wvalid && m_axi_wready;
  assign data_read      = w_w_hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wstate     <= W_IDLE;
      r_beats_left <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (burst_len_empty_n) begin
            r_beats_left <= burst_len_dout;
            r_wstate     <= W_BURST;
          end
        end
        W_BURST: begin
          if (w_w_hs) begin
            if (r_beats_left == '0) begin
              r_wstate <= W_IDLE;
            end else begin
              r_beats_left <= r_beats_left - BURST_LEN_WIDTH'(1);
            end
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- B path ----------------
  fifo_srl #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (BURST_LEN_WIDTH)
  ) u_len_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_din   (w_req_len),
    .i_push  (addr_read),
    .i_pop   (w_b_hs),
    .o_dout  (w_len_dout),
    .o_empty (w_len_empty),
    .o_full  (w_len_full)
  );

  assign m_axi_bready = rst_n && resp_full_n && !w_len_empty;
  assign w_b_hs       = m_axi_bvalid && m_axi_bready;
  // widened before the increment so a max-length burst reports 2^BURST_LEN_WIDTH beats
  assign w_beats      = {1'b0, w_len_dout} + (BURST_LEN_WIDTH + 1)'(1);
  assign resp_din     = {(m_axi_bresp != AXI_RESP_OKAY), w_beats};
  assign resp_write   = w_b_hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({addr_read, w_b_hs})
        2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_write_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_burst_write_issuer                                                |
// | Scoreboard bench: directed requests, AXI slave model, monitor.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_burst_write_issuer;

  localparam int AW = 64;
  localparam int DW = 512;
  localparam int LW = 8;
  localparam int MO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [LW+AW-1:0] addr_dout = '0;
  logic            addr_empty_n = 1'b0;
  logic            addr_read;
  logic [LW-1:0]   burst_len_dout = '0;
  logic            burst_len_empty_n = 1'b0;
  logic            burst_len_read;
  logic [DW-1:0]   data_dout = '0;
  logic            data_empty_n = 1'b0;
  logic            data_read;
  logic [AW-1:0]   m_axi_awaddr;
  logic [LW-1:0]   m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awvalid;
  logic            m_axi_awready = 1'b1;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_wlast;
  logic            m_axi_wvalid;
  logic            m_axi_wready = 1'b1;
  logic [1:0]      m_axi_bresp = 2'b00;
  logic            m_axi_bvalid = 1'b0;
  logic            m_axi_bready;
  logic [LW+1:0]   resp_din;
  logic            resp_full_n = 1'b1;
  logic            resp_write;

  burst_write_issuer #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .BURST_LEN_WIDTH (LW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .addr_dout         (addr_dout),
    .addr_empty_n      (addr_empty_n),
    .addr_read         (addr_read),
    .burst_len_dout    (burst_len_dout),
    .burst_len_empty_n (burst_len_empty_n),
    .burst_len_read    (burst_len_read),
    .data_dout         (data_dout),
    .data_empty_n      (data_empty_n),
    .data_read         (data_read),
    .m_axi_awaddr      (m_axi_awaddr),
    .m_axi_awlen       (m_axi_awlen),
    .m_axi_awsize      (m_axi_awsize),
    .m_axi_awburst     (m_axi_awburst),
    .m_axi_awvalid     (m_axi_awvalid),
    .m_axi_awready     (m_axi_awready),
    .m_axi_wdata       (m_axi_wdata),
    .m_axi_wstrb       (m_axi_wstrb),
    .m_axi_wlast       (m_axi_wlast),
    .m_axi_wvalid      (m_axi_wvalid),
    .m_axi_wready      (m_axi_wready),
    .m_axi_bresp       (m_axi_bresp),
    .m_axi_bvalid      (m_axi_bvalid),
    .m_axi_bready      (m_axi_bready),
    .resp_din          (resp_din),
    .resp_full_n       (resp_full_n),
    .resp_write        (resp_write)
  );

  always #5 clk = ~clk;

  // upstream FIFO contents and scoreboard queues
  logic [LW+AW-1:0] addr_q[$];
  logic [LW-1:0]    blen_q[$];
  logic [DW-1:0]    data_q[$];
  logic [LW+AW-1:0] exp_aw[$];
  logic [DW:0]      exp_w[$];
  logic [LW+1:0]    exp_resp[$];
  logic [1:0]       b_plan[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   req_id = 0;
  int   aw_cnt = 0;
  int   b_cnt = 0;
  int   b_avail = 0;
  logic b_en = 1'b1;
  logic data_gate = 1'b1;
  logic exp_reload = 1'b0;

  logic          prev_load = 1'b0;
  logic          prev_stall = 1'b0;
  logic          prev_bhs = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [LW-1:0] prev_len = '0;

  task automatic check(input string name, input logic [599:0] act, input logic [599:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int req, input int beat);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) begin
      d[i*32 +: 32] = {16'(req), 16'(beat)} ^ (32'(i) * 32'h9E37_79B9);
    end
    return d;
  endfunction

  task automatic issue(input logic [AW-1:0] addr, input logic [LW-1:0] len, input logic [1:0] bresp);
    logic [DW-1:0] d;
    addr_q.push_back({len, addr});
    blen_q.push_back(len);
    for (int b = 0; b <= int'(len); b++) begin
      d = beat_data(req_id, b);
      data_q.push_back(d);
      exp_w.push_back({(b == int'(len)), d});
    end
    exp_aw.push_back({len, addr});
    b_plan.push_back(bresp);
    exp_resp.push_back({(bresp != 2'b00), ({1'b0, len} + 9'd1)});
    req_id++;
  endtask

  task automatic flush_all();
    addr_q.delete(); blen_q.delete(); data_q.delete();
    exp_aw.delete(); exp_w.delete(); exp_resp.delete(); b_plan.delete();
    b_avail = 0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((exp_aw.size() != 0 || exp_w.size() != 0 || exp_resp.size() != 0) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_timeout", 600'(c >= budget), 600'(0));
  endtask

  // drive FWFT upstream outputs and the B channel after the test tasks settle
  always @(posedge clk) begin
    #2;
    addr_empty_n      = (addr_q.size() != 0);
    addr_dout         = addr_empty_n ? addr_q[0] : '0;
    burst_len_empty_n = (blen_q.size() != 0);
    burst_len_dout    = burst_len_empty_n ? blen_q[0] : '0;
    data_empty_n      = (data_q.size() != 0) && data_gate;
    data_dout         = (data_q.size() != 0) ? data_q[0] : '0;
    m_axi_bvalid      = b_en && (b_avail > 0) && (b_plan.size() != 0);
    m_axi_bresp       = (b_plan.size() != 0) ? b_plan[0] : 2'b00;
  end

  // monitor: handshakes are decided by the values stable at the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_outputs", 600'({addr_read, burst_len_read, data_read, m_axi_awvalid,
                                 m_axi_wvalid, m_axi_bready, resp_write}), 600'(0));
      prev_load  = 1'b0;
      prev_stall = 1'b0;
      prev_bhs   = 1'b0;
    end else begin
      if (prev_load)  check("aw_latency", 600'(m_axi_awvalid), 600'(1));
      if (prev_stall) check("aw_hold", 600'({m_axi_awvalid, m_axi_awlen, m_axi_awaddr}),
                            600'({1'b1, prev_len, prev_addr}));
      if (exp_reload && prev_bhs) begin
        check("reload_after_b", 600'(addr_read), 600'(1));
        exp_reload = 1'b0;
      end
      if (!resp_full_n) check("bready_blocked", 600'(m_axi_bready), 600'(0));
      if (m_axi_wvalid) check("wvalid_gate", 600'(data_empty_n && data_gate), 600'(1));
      check("data_read", 600'(data_read), 600'(m_axi_wvalid && m_axi_wready));

      if (m_axi_awvalid && m_axi_awready) begin
        if (exp_aw.size() == 0) check("aw_extra", 600'(1), 600'(0));
        else begin
          check("aw_fields", 600'({m_axi_awlen, m_axi_awaddr}), 600'(exp_aw[0]));
          void'(exp_aw.pop_front());
        end
        check("aw_size_burst", 600'({m_axi_awsize, m_axi_awburst}), 600'({3'd6, 2'b01}));
        aw_cnt++;
        b_avail++;
      end

      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_w.size() == 0) check("w_extra", 600'(1), 600'(0));
        else begin
          check("w_beat", 600'({m_axi_wlast, m_axi_wdata}), 600'(exp_w[0]));
          void'(exp_w.pop_front());
        end
        check("wstrb", 600'(m_axi_wstrb), 600'({(DW/8){1'b1}}));
      end

      check("resp_write", 600'(resp_write), 600'(m_axi_bvalid && m_axi_bready));
      if (resp_write) begin
        if (exp_resp.size() == 0) check("resp_extra", 600'(1), 600'(0));
        else begin
          check("resp_din", 600'(resp_din), 600'(exp_resp[0]));
          void'(exp_resp.pop_front());
        end
      end

      if (m_axi_bvalid && m_axi_bready) begin
        b_avail--;
        if (b_plan.size() != 0) void'(b_plan.pop_front());
        b_cnt++;
      end
      if (addr_read && addr_q.size() != 0)      void'(addr_q.pop_front());
      if (burst_len_read && blen_q.size() != 0) void'(blen_q.pop_front());
      if (data_read && data_q.size() != 0)      void'(data_q.pop_front());

      prev_load  = addr_read;
      prev_stall = m_axi_awvalid && !m_axi_awready;
      prev_addr  = m_axi_awaddr;
      prev_len   = m_axi_awlen;
      prev_bhs   = m_axi_bvalid && m_axi_bready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    // request present during reset: every handshake output must stay low
    @(posedge clk); #1;
    issue(64'h1000, 8'd3, 2'b00);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle(100);

    issue(64'h2000, 8'd0, 2'b00);
    wait_idle(100);

    issue(64'h1_0000, 8'd255, 2'b00);
    wait_idle(1000);

    // outstanding limit with B withheld
    b_en = 1'b0;
    base = aw_cnt;
    for (int i = 0; i < 20; i++) issue(64'h4_0000 + 64'(i * 64), 8'd0, 2'b00);
    repeat (40) @(posedge clk);
    #2;
    check("aw_at_limit", 600'(aw_cnt - base), 600'(16));
    check("addr_read_stalled", 600'(addr_read), 600'(0));
    @(posedge clk); #1;
    exp_reload = 1'b1;
    b_en = 1'b1;
    begin
      int c;
      int b0;
      b0 = b_cnt;
      c = 0;
      while (b_cnt == b0 && c < 10) begin
        @(posedge clk); #1;
        c++;
      end
      b_en = 1'b0;
      check("single_b_timeout", 600'(c >= 10), 600'(0));
    end
    repeat (3) @(posedge clk);
    #1;
    check("aw_after_release", 600'(aw_cnt - base), 600'(17));
    b_en = 1'b1;
    wait_idle(200);

    // AW back-pressure with a gated data stream
    m_axi_awready = 1'b0;
    issue(64'h3000, 8'd7, 2'b00);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      data_gate = ~data_gate;
    end
    data_gate = 1'b1;
    m_axi_awready = 1'b1;
    wait_idle(100);

    issue(64'h4000, 8'd1, 2'b10);
    wait_idle(100);

    // response FIFO full: B must stay pending
    resp_full_n = 1'b0;
    base = b_cnt;
    issue(64'h5000, 8'd2, 2'b00);
    repeat (15) @(posedge clk);
    #1;
    check("b_pending", 600'({b_avail[7:0], m_axi_bvalid}), 600'({8'd1, 1'b1}));
    check("b_not_taken", 600'(b_cnt - base), 600'(0));
    resp_full_n = 1'b1;
    wait_idle(100);

    // reset in the middle of a burst
    m_axi_awready = 1'b0;
    issue(64'h6000, 8'd15, 2'b00);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    flush_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valids", 600'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 600'(0));
    check("post_rst_outstanding", 600'(dut.r_outstanding), 600'(0));
    @(posedge clk); #1;
    m_axi_awready = 1'b1;
    issue(64'h7000, 8'd2, 2'b00);
    wait_idle(100);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
